// File: rtl/pc_branch_unit_if.sv
// Controller/datapath bundle for pc_branch_unit: strobes, instruction fields,
// flags and register/memory data in, PC/link/branch status out.
interface pc_branch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              PCEn;
  logic              PCWrite;
  logic              PCRead;
  logic [3:0]        OpCode;
  logic [3:0]        RDest;
  logic [3:0]        OpCodeExt_ImmHi;
  logic [3:0]        RSource_ImmLo;
  logic [4:0]        Flags;
  logic [DATA_W-1:0] RTargetData;
  logic [ADDR_W-1:0] DataAddr;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] LinkData;
  logic              LinkWe;
  logic              Taken;
  logic [15:0]       BranchCount;

  modport master (
    output PCEn, PCWrite, PCRead, OpCode, RDest, OpCodeExt_ImmHi, RSource_ImmLo,
           Flags, RTargetData, DataAddr,
    input  PC, MemAddr, LinkData, LinkWe, Taken, BranchCount
  );

  modport slave (
    input  PCEn, PCWrite, PCRead, OpCode, RDest, OpCodeExt_ImmHi, RSource_ImmLo,
           Flags, RTargetData, DataAddr,
    output PC, MemAddr, LinkData, LinkWe, Taken, BranchCount
  );
endinterface

// File: rtl/pc_branch_unit.sv
// PC register and branch resolution (Bcond/Jcond/JAL/JR) with JAL link write.
// Define PC_BRANCH_COUNT_EN to build the saturating taken-branch counter.
module pc_branch_unit #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            Reset,
  pc_branch_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc_p1;
  logic              link_pend_p1;
  logic              taken;
  logic [DATA_W-1:0] link_data;
  logic              link_we;

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0] reg_target;
  logic [ADDR_W-1:0] eval_pc;
  logic              eval_taken;
  logic              eval_link;

  function automatic logic cond_true(input logic [3:0] code, input logic [4:0] flags);
    logic n, z, f, l, c;
    {n, z, f, l, c} = flags;
    case (code)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return c;
      4'b0011: return !c;
      4'b0100: return l;
      4'b0101: return !l;
      4'b0110: return n;
      4'b0111: return !n;
      4'b1000: return f;
      4'b1001: return !f;
      4'b1010: return !l && !z;
      4'b1011: return l || z;
      4'b1100: return !n && !z;
      4'b1101: return n || z;
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic signed [ADDR_W-1:0] sext_disp(input logic signed [7:0] d);
    return ADDR_W'(d);
  endfunction

  assign pc_plus1   = pc + ONE;
  assign disp_ext   = sext_disp({bus.OpCodeExt_ImmHi, bus.RSource_ImmLo});
  assign reg_target = ADDR_W'(bus.RTargetData);

  always_comb begin
    eval_pc    = pc_plus1;
    eval_taken = 1'b0;
    eval_link  = 1'b0;
    if (bus.OpCode == 4'b1100) begin
      if (cond_true(bus.RDest, bus.Flags)) begin
        eval_pc    = pc + disp_ext;
        eval_taken = 1'b1;
      end
    end else if (bus.OpCode == 4'b0100) begin
      case (bus.OpCodeExt_ImmHi)
        4'b1100: begin
          if (cond_true(bus.RDest, bus.Flags)) begin
            eval_pc    = reg_target;
            eval_taken = 1'b1;
          end
        end
        4'b1000: begin
          eval_pc    = reg_target;
          eval_taken = 1'b1;
          eval_link  = 1'b1;
        end
        4'b1111: begin
          eval_pc    = reg_target;
          eval_taken = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: evaluated next PC held until commit; PCWrite outranks PCEn.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      pc           <= RESET_ADDR;
      next_pc_p1   <= RESET_ADDR + ONE;
      link_pend_p1 <= 1'b0;
      taken        <= 1'b0;
      link_data    <= '0;
      link_we      <= 1'b0;
    end else begin
      link_we <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.PCWrite) begin
            pc    <= pc_plus1;
            taken <= 1'b0;
          end else if (bus.PCEn) begin
            next_pc_p1   <= eval_pc;
            taken        <= eval_taken;
            link_pend_p1 <= eval_link;
            state        <= EVAL;
          end
        end
        EVAL: begin
          if (bus.PCWrite) begin
            pc <= next_pc_p1;
            if (link_pend_p1) begin
              link_data <= DATA_W'(pc_plus1);
              link_we   <= 1'b1;
            end
            link_pend_p1 <= 1'b0;
            state        <= bus.PCEn ? IDLE : COMMIT;
          end else if (bus.PCEn) begin
            next_pc_p1   <= eval_pc;
            taken        <= eval_taken;
            link_pend_p1 <= eval_link;
          end
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PC_BRANCH_COUNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [15:0] branch_count;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      branch_count <= '0;
    else if (state == EVAL && bus.PCWrite && taken)
      branch_count <= sat_inc(branch_count);
  end

  assign bus.BranchCount = branch_count;
`else
  assign bus.BranchCount = '0;
`endif

  assign bus.PC       = pc;
  assign bus.MemAddr  = bus.PCRead ? pc : bus.DataAddr;
  assign bus.LinkData = link_data;
  assign bus.LinkWe   = link_we;
  assign bus.Taken    = taken;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed-vector bench for pc_branch_unit with hand-computed expectations.
module tb_pc_branch_unit;

  logic clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  pc_branch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  pc_branch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0010)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle, PCEn with the given fields, then a PCWrite commit.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] hi,
                           input logic [3:0] lo, input logic [4:0] flags, input logic [15:0] rt);
    tick();
    bus.OpCode          = op;
    bus.RDest           = rd;
    bus.OpCodeExt_ImmHi = hi;
    bus.RSource_ImmLo   = lo;
    bus.Flags           = flags;
    bus.RTargetData     = rt;
    bus.PCEn            = 1'b1;
    tick();
    bus.PCEn    = 1'b0;
    bus.PCWrite = 1'b1;
    tick();
    bus.PCWrite = 1'b0;
  endtask

  function automatic logic [15:0] cnt_exp(input int n);
`ifdef PC_BRANCH_COUNT_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  initial begin
    Reset               = 1'b1;
    bus.PCEn            = 1'b0;
    bus.PCWrite         = 1'b0;
    bus.PCRead          = 1'b0;
    bus.OpCode          = '0;
    bus.RDest           = '0;
    bus.OpCodeExt_ImmHi = '0;
    bus.RSource_ImmLo   = '0;
    bus.Flags           = '0;
    bus.RTargetData     = '0;
    bus.DataAddr        = '0;
    repeat (2) tick();

    check_val("rst_pc",    bus.PC, 32'h0010);
    check_val("rst_taken", bus.Taken, 0);
    check_val("rst_linkwe", bus.LinkWe, 0);
    check_val("rst_link",  bus.LinkData, 0);
    check_val("rst_cnt",   bus.BranchCount, 0);
    Reset = 1'b0;
    tick();

    bus.PCWrite = 1'b1;
    tick();
    bus.PCWrite = 1'b0;
    check_val("idle_wr_pc",    bus.PC, 32'h0011);
    check_val("idle_wr_taken", bus.Taken, 0);
    check_val("idle_wr_linkwe", bus.LinkWe, 0);

    run_instr(4'b0100, 4'h0, 4'b1111, 4'h0, 5'b0, 16'h0020);
    check_val("jr_pc",    bus.PC, 32'h0020);
    check_val("jr_taken", bus.Taken, 1);

    run_instr(4'b1100, 4'b0000, 4'hF, 4'hE, 5'b01000, 16'h0);
    check_val("beq_t_pc",    bus.PC, 32'h001E);
    check_val("beq_t_taken", bus.Taken, 1);

    run_instr(4'b0100, 4'h0, 4'b1111, 4'h0, 5'b0, 16'h0020);
    run_instr(4'b1100, 4'b0000, 4'hF, 4'hE, 5'b00000, 16'h0);
    check_val("beq_nt_pc",    bus.PC, 32'h0021);
    check_val("beq_nt_taken", bus.Taken, 0);

    run_instr(4'b0100, 4'h0, 4'b1111, 4'h0, 5'b0, 16'h0040);
    run_instr(4'b0100, 4'h3, 4'b1000, 4'h0, 5'b0, 16'h1234);
    check_val("jal_pc",     bus.PC, 32'h1234);
    check_val("jal_link",   bus.LinkData, 32'h0041);
    check_val("jal_linkwe", bus.LinkWe, 1);
    tick();
    check_val("jal_linkwe_drop", bus.LinkWe, 0);
    check_val("cnt_mid", bus.BranchCount, 32'(cnt_exp(5)));

    bus.PCRead   = 1'b1;
    bus.DataAddr = 16'hBEEF;
    #1;
    check_val("memaddr_pc", bus.MemAddr, 32'h1234);
    bus.PCRead = 1'b0;
    #1;
    check_val("memaddr_data", bus.MemAddr, 32'hBEEF);

    run_instr(4'b0100, 4'h0, 4'b1111, 4'h0, 5'b0, 16'hFFFF);
    run_instr(4'b0000, 4'h1, 4'h2, 4'h3, 5'b0, 16'h0);
    check_val("wrap_pc",    bus.PC, 32'h0000);
    check_val("wrap_taken", bus.Taken, 0);

    run_instr(4'b0100, 4'b1111, 4'b1100, 4'h0, 5'b11111, 16'h5555);
    check_val("jnever_pc",    bus.PC, 32'h0001);
    check_val("jnever_taken", bus.Taken, 0);

    run_instr(4'b0100, 4'b1110, 4'b1100, 4'h0, 5'b0, 16'h0300);
    check_val("juc_pc", bus.PC, 32'h0300);

    run_instr(4'b1100, 4'b1010, 4'h0, 4'h5, 5'b00000, 16'h0);
    check_val("blo_pc", bus.PC, 32'h0305);

    tick();
    bus.OpCode          = 4'b0100;
    bus.OpCodeExt_ImmHi = 4'b1111;
    bus.RTargetData     = 16'h7777;
    bus.PCEn            = 1'b1;
    tick();
    bus.PCEn = 1'b0;
    Reset    = 1'b1;
    #1;
    check_val("midrst_pc",    bus.PC, 32'h0010);
    check_val("midrst_taken", bus.Taken, 0);
    check_val("midrst_cnt",   bus.BranchCount, 0);
    Reset = 1'b0;
    tick();
    bus.PCWrite = 1'b1;
    tick();
    bus.PCWrite = 1'b0;
    check_val("midrst_wr_pc", bus.PC, 32'h0011);

    run_instr(4'b0100, 4'h0, 4'b1111, 4'h0, 5'b0, 16'h0050);
    run_instr(4'b0100, 4'h0, 4'b1111, 4'h0, 5'b0, 16'h0060);
    run_instr(4'b0100, 4'h0, 4'b1111, 4'h0, 5'b0, 16'h0070);
    run_instr(4'b0001, 4'h0, 4'h0, 4'h0, 5'b0, 16'h0);
    run_instr(4'b0001, 4'h0, 4'h0, 4'h0, 5'b0, 16'h0);
    check_val("cnt_pc",  bus.PC, 32'h0072);
    check_val("cnt_val", bus.BranchCount, 32'(cnt_exp(3)));

    tick();
    bus.OpCode          = 4'b0100;
    bus.OpCodeExt_ImmHi = 4'b1111;
    bus.RTargetData     = 16'h0100;
    bus.PCEn            = 1'b1;
    tick();
    bus.OpCode = 4'b0010;
    tick();
    bus.PCEn    = 1'b0;
    bus.PCWrite = 1'b1;
    tick();
    bus.PCWrite = 1'b0;
    check_val("reeval_pc",    bus.PC, 32'h0073);
    check_val("reeval_taken", bus.Taken, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage that sits directly downstream of the CPU controller FSM and consumes its PCEn, PCWrite and PCRead strobes.
- Holds the architectural PC and evaluates Bcond, Jcond, JAL and sequential next-PC against the PSR flags.
- Commits the new PC, produces the JAL link value, and drives the shared memory address mux (PC vs data address).

Parameters:
- ADDR_W, 16, width of PC and memory address.
- DATA_W, 16, width of register-file data (jump target, link value).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PCEn  in  1  controller JEX strobe: evaluate next PC.
- PCWrite  in  1  controller JEXWB strobe: commit next PC.
- PCRead  in  1  controller FETCH/PCUPDATE strobe: MemAddr selects PC.
- OpCode  in  4  instruction [15:12].
- RDest  in  4  instruction [11:8]: condition code, or Rlink index for JAL.
- OpCodeExt_ImmHi  in  4  instruction [7:4].
- RSource_ImmLo  in  4  instruction [3:0].
- Flags  in  5  PSR {N,Z,F,L,C}, bit4..bit0.
- RTargetData  in  DATA_W  register-file read data of the target register.
- DataAddr  in  ADDR_W  load/store address.
- PC  out  ADDR_W  architectural PC.
- MemAddr  out  ADDR_W  combinational: PCRead ? PC : DataAddr.
- LinkData  out  DATA_W  PC+1, zero-extended/truncated to DATA_W, registered.
- LinkWe  out  1  one-cycle register-file write pulse for JAL.
- Taken  out  1  registered: last evaluation redirected the PC.
- BranchCount  out  16  taken-branch counter (see Optional Feature).

Behaviour:
- Reset (async): PC=RESET_PC, NextPC=RESET_PC+1, LinkData=0, LinkWe=0, Taken=0, BranchCount=0, state=IDLE. Reset asserted mid-sequence discards any pending NextPC.
- States:
  - IDLE --PCEn--> EVAL.
  - EVAL (NextPC latched) --PCWrite--> COMMIT.
  - EVAL --PCEn--> EVAL (re-evaluate and overwrite).
  - COMMIT --> IDLE unconditionally after one cycle.
- Evaluation on the PCEn clock edge, using the instruction fields at that edge:
  - Bcond (OpCode=1100): if cond true, NextPC = PC + sext({ImmHi,ImmLo}) mod 2^ADDR_W; else PC+1.
  - Jcond (0100/ext 1100): if cond true, NextPC = RTargetData[ADDR_W-1:0]; else PC+1.
  - JAL (0100/ext 1000): NextPC = RTargetData; always taken; link pending.
  - JR (0100/ext 1111): NextPC = RTargetData; always taken.
  - All other opcodes: NextPC = PC+1, Taken=0.
- Condition codes (RDest):
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N.
  - FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z; LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 always; 1111 never.
- PCWrite edge in EVAL: PC <= NextPC. If a JAL is pending, LinkData <= old PC+1 and LinkWe=1 for exactly this cycle.
- PCWrite in IDLE (no prior PCEn): PC <= PC+1, Taken=0, no link.
- PCWrite and PCEn in the same cycle: PCWrite has priority, then the state goes to IDLE. PCEn is ignored.
- PC+1 and displacement wrap modulo 2^ADDR_W (0xFFFF+1 = 0x0000).
- PCRead only affects MemAddr; it has no sequential effect.

Optional Feature:
- Macro: PC_BRANCH_COUNT_EN.
- Defined: BranchCount increments by 1 on each commit with Taken=1 and saturates at 0xFFFF. Reset clears it.
- Undefined: BranchCount is tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset with RESET_PC=0x0010, Reset released; PCWrite pulse in IDLE -> PC=0x0011, Taken=0, LinkWe=0.
- PC=0x0020, Bcond EQ, disp 0xFE, Z=1; PCEn then PCWrite -> PC=0x001E, Taken=1. Same with Z=0 -> PC=0x0021.
- PC=0x0040, JAL, RTargetData=0x1234 -> PC=0x1234, LinkData=0x0041, LinkWe high exactly one cycle.
- PC=0xFFFF, ALU opcode 0000; PCEn, PCWrite -> PC=0x0000 (wrap); Jcond code 1111 -> not taken.
- Reset asserted between PCEn and PCWrite -> PC=RESET_PC immediately; a following PCWrite yields RESET_PC+1.
- PC_BRANCH_COUNT_EN defined: 3 taken + 2 untaken commits -> BranchCount=3. Macro undefined -> BranchCount=0.
